reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 112 +++++++++++
 tb/tb_reset_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// PLL-lock driven reset sequencer: waits for a stable lock, holds downstream reset, then releases.
// Define RESET_SEQ_LOSS_CNT_EN to enable the saturating lock-loss counter on o_lock_loss_cnt.
module reset_sequencer #(
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned RST_HOLD_CYCLES    = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_pll_locked,
    input  logic       i_clr_flags,
    output logic       o_rst_n,
    output logic       o_ready,
    output logic       o_lock_lost,
    output logic [7:0] o_lock_loss_cnt,
    output logic [1:0] o_state
);

    typedef enum logic [1:0] {
        StWait   = 2'd0,
        StStable = 2'd1,
        StHold   = 2'd2,
        StRun    = 2'd3
    } state_e;

    localparam logic [15:0] StableLast = 16'(LOCK_STABLE_CYCLES - 1);
    localparam logic [15:0] HoldLast   = 16'(RST_HOLD_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        locked_m, locked_s;
    logic        rst_n_q, ready_q;
    logic        lost_q, lost_d;
    logic        lock_loss;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            locked_m <= 1'b0;
            locked_s <= 1'b0;
            state_q  <= StWait;
            cnt_q    <= '0;
            rst_n_q  <= 1'b0;
            ready_q  <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            locked_m <= i_pll_locked;
            locked_s <= locked_m;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rst_n_q  <= (state_d == StRun);
            ready_q  <= (state_d == StRun);
            lost_q   <= lost_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWait: begin
                if (locked_s) state_d = StStable;
            end
            StStable: begin
                if (!locked_s)                state_d = StWait;
                else if (cnt_q == StableLast) state_d = StStable == StStable ? StHold : StHold;
            end
            StHold: begin
                if (!locked_s)              state_d = StWait;
                else if (cnt_q == HoldLast) state_d = StRun;
            end
            StRun: begin
                if (!locked_s) state_d = StWait;
            end
            default: state_d = StWait;
        endcase
    end

    // Counter only runs while timing a window and restarts on every state change.
    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if ((state_d != state_q) || (state_q == StWait) || (state_q == StRun)) begin
            cnt_d = '0;
        end
    end

    assign lock_loss = (state_q == StRun) && !locked_s;
    // A new loss beats a coincident clear.
    assign lost_d    = lock_loss | (lost_q & ~i_clr_flags);

`ifdef RESET_SEQ_LOSS_CNT_EN
    logic [7:0] loss_cnt_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            loss_cnt_q <= '0;
        end else if (lock_loss) begin
            if (i_clr_flags)               loss_cnt_q <= 8'd1;
            else if (loss_cnt_q != 8'hff)  loss_cnt_q <= loss_cnt_q + 8'd1;
        end else if (i_clr_flags) begin
            loss_cnt_q <= '0;
        end
    end

    assign o_lock_loss_cnt = loss_cnt_q;
`else
    assign o_lock_loss_cnt = 8'd0;
`endif

    assign o_rst_n     = rst_n_q;
    assign o_ready     = ready_q;
    assign o_lock_lost = lost_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed vector table, hand-written corner sequences
// and randomized lock/clear/reset stimulus checked against a streak-based reference model.
module tb_reset_sequencer;

    localparam int unsigned L = 8;
    localparam int unsigned H = 4;
    localparam int          T = L + H + 2;

`ifdef RESET_SEQ_LOSS_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       clr_flags;
    logic       o_rst_n;
    logic       o_ready;
    logic       o_lock_lost;
    logic [7:0] o_lock_loss_cnt;
    logic [1:0] o_state;

    always #5 clk = ~clk;

    reset_sequencer #(
        .LOCK_STABLE_CYCLES(L),
        .RST_HOLD_CYCLES   (H)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_pll_locked   (pll_locked),
        .i_clr_flags    (clr_flags),
        .o_rst_n        (o_rst_n),
        .o_ready        (o_ready),
        .o_lock_lost    (o_lock_lost),
        .o_lock_loss_cnt(o_lock_loss_cnt),
        .o_state        (o_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the FSM sees the input two edges late; everything follows from the
    // number of consecutive edges at which it has seen the lock high.
    logic m_s1, m_s2;
    int   streak;
    logic m_lost;
    int   m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_state();
        if (streak == 0)              return 0;
        else if (streak <= int'(L))   return 1;
        else if (streak <= int'(L+H)) return 2;
        else                          return 3;
    endfunction

    task automatic model_edge();
        logic seen;
        bit   was_run;
        if (!rst_n) begin
            m_s1 = 1'b0; m_s2 = 1'b0; streak = 0; m_lost = 1'b0; m_cnt = 0;
        end else begin
            seen    = m_s2;
            m_s2    = m_s1;
            m_s1    = pll_locked;
            was_run = (streak >= int'(L + H + 1));
            if (!seen)              streak = 0;
            else if (streak < 1000) streak++;
            if (was_run && !seen) begin
                m_lost = 1'b1;
                if (CntEn) m_cnt = clr_flags ? 1 : (m_cnt >= 255 ? 255 : m_cnt + 1);
            end else if (clr_flags) begin
                m_lost = 1'b0;
                m_cnt  = 0;
            end
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, " rst_n"}, 32'(o_rst_n), 32'(exp_state() == 3));
        chk({tag, " ready"}, 32'(o_ready), 32'(exp_state() == 3));
        chk({tag, " state"}, 32'(o_state), 32'(exp_state()));
        chk({tag, " lost"},  32'(o_lock_lost), 32'(m_lost));
        chk({tag, " cnt"},   32'(o_lock_loss_cnt), 32'(m_cnt));
    endtask

    // Caller has just made the edge-0 condition true; counts edges until o_rst_n rises.
    task automatic measure(input string tag, input int exp);
        int got;
        got = -1;
        for (int i = 0; i < 100; i++) begin
            tick(tag);
            if (o_rst_n === 1'b1) begin
                got = i;
                break;
            end
        end
        chk({tag, " release edge"}, 32'(got), 32'(exp));
    endtask

    typedef struct {
        logic       rst_n;
        logic       locked;
        logic [1:0] exp_state;
        logic       exp_rst_n;
    } vec_t;

    vec_t vecs[$];

    initial begin
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        clr_flags  = 1'b0;

        // Power-up: 5 reset cycles, 2 idle, then lock raised (row 7 is edge 0).
        for (int i = 0; i < 5; i++) vecs.push_back('{1'b0, 1'b0, 2'd0, 1'b0});
        for (int i = 0; i < 2; i++) vecs.push_back('{1'b1, 1'b0, 2'd0, 1'b0});
        for (int k = 0; k < 16; k++) begin
            if (k < 2)       vecs.push_back('{1'b1, 1'b1, 2'd0, 1'b0});
            else if (k < 10) vecs.push_back('{1'b1, 1'b1, 2'd1, 1'b0});
            else if (k < 14) vecs.push_back('{1'b1, 1'b1, 2'd2, 1'b0});
            else             vecs.push_back('{1'b1, 1'b1, 2'd3, 1'b1});
        end

        foreach (vecs[i]) begin
            rst_n      = vecs[i].rst_n;
            pll_locked = vecs[i].locked;
            tick("vec");
            chk($sformatf("vec%0d state", i), 32'(o_state), 32'(vecs[i].exp_state));
            chk($sformatf("vec%0d rst_n", i), 32'(o_rst_n), 32'(vecs[i].exp_rst_n));
            chk($sformatf("vec%0d ready", i), 32'(o_ready), 32'(vecs[i].exp_rst_n));
        end

        // Run-time loss: outputs fall two edges after the first edge sampling the low lock.
        pll_locked = 1'b0;
        tick("loss e0");
        chk("loss e0 hold", 32'(o_rst_n), 32'd1);
        tick("loss e1");
        chk("loss e1 hold", 32'(o_rst_n), 32'd1);
        tick("loss e2");
        chk("loss e2 rst_n", 32'(o_rst_n), 32'd0);
        chk("loss e2 ready", 32'(o_ready), 32'd0);
        chk("loss e2 lost",  32'(o_lock_lost), 32'd1);
        chk("loss e2 cnt",   32'(o_lock_loss_cnt), CntEn ? 32'd1 : 32'd0);
        pll_locked = 1'b1;
        measure("relock", T);

        // Glitch in S_STABLE after a clean reset.
        pll_locked = 1'b0;
        rst_n      = 1'b0;
        tick("glitch rst");
        rst_n = 1'b1;
        repeat (2) tick("glitch idle");
        pll_locked = 1'b1;
        repeat (6) tick("glitch lock");
        chk("glitch in stable", 32'(o_state), 32'd1);
        pll_locked = 1'b0;
        repeat (3) tick("glitch low");
        chk("glitch state", 32'(o_state), 32'd0);
        chk("glitch rst_n", 32'(o_rst_n), 32'd0);
        chk("glitch lost",  32'(o_lock_lost), 32'd0);
        pll_locked = 1'b1;
        measure("glitch relock", T);

        // Reset pulse while in S_HOLD with lock held high.
        rst_n = 1'b0;
        tick("hold pre rst");
        rst_n = 1'b1;
        repeat (12) tick("hold approach");
        chk("in hold", 32'(o_state), 32'd2);
        rst_n = 1'b0;
        tick("hold rst");
        chk("hold rst state", 32'(o_state), 32'd0);
        chk("hold rst rst_n", 32'(o_rst_n), 32'd0);
        rst_n = 1'b1;
        measure("hold rerun", T);

        // 260 loss/relock cycles to reach saturation.
        for (int n = 0; n < 260; n++) begin
            pll_locked = 1'b0;
            repeat (3) tick("sat low");
            pll_locked = 1'b1;
            repeat (16) tick("sat high");
        end
        chk("sat cnt",  32'(o_lock_loss_cnt), CntEn ? 32'd255 : 32'd0);
        chk("sat lost", 32'(o_lock_lost), 32'd1);
        clr_flags = 1'b1;
        tick("clr");
        clr_flags = 1'b0;
        chk("clr cnt",  32'(o_lock_loss_cnt), 32'd0);
        chk("clr lost", 32'(o_lock_lost), 32'd0);

        // Clear coincident with a new loss: the set wins.
        pll_locked = 1'b0;
        repeat (2) tick("coinc low");
        clr_flags = 1'b1;
        tick("coinc");
        clr_flags = 1'b0;
        chk("coinc lost", 32'(o_lock_lost), 32'd1);
        chk("coinc cnt",  32'(o_lock_loss_cnt), CntEn ? 32'd1 : 32'd0);
        chk("coinc rst_n", 32'(o_rst_n), 32'd0);

        // Randomized stimulus against the model.
        for (int i = 0; i < 4000; i++) begin
            if (pll_locked) pll_locked = ($urandom_range(0, 24) == 0) ? 1'b0 : 1'b1;
            else            pll_locked = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
            clr_flags = ($urandom_range(0, 15) == 0);
            rst_n     = ($urandom_range(0, 299) != 0);
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
